// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the LTC2308 serial-link responder: FSM state encoding,
// config-word bit positions, reset config and word widths, plus small helpers
// used to decode the config word and to form the returned result.
// -----------------------------------------------------------------------------
package adc_pkg;

  localparam int RESULT_W = 12;
  localparam int CFG_W    = 6;

  // Config word bit positions, MSB first on the wire: S/D, O/S, S1, S0, UNI, SLP.
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // Single-ended, channel 0, unipolar, no sleep.
  localparam logic [CFG_W-1:0] RESET_CFG = 6'b100010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_READY = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  // Channel address is {S1, S0, O/S}.
  function automatic logic [2:0] cfg_chan(input logic [CFG_W-1:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

  // Bipolar mode (UNI=0) returns two's complement: flip the MSB of the
  // offset-binary channel value.
  function automatic logic [RESULT_W-1:0] to_result(input logic [RESULT_W-1:0] val,
                                                    input logic uni);
    return val ^ {~uni, {(RESULT_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/adc_spi_responder_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous master pin followed by an edge
// register; produces single-cycle rise and fall pulses on the synchronized copy.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   raw pin from the ADC master
//   rise     out  one-cycle pulse on a synchronized 0->1 transition
//   fall     out  one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/adc_spi_responder.sv
// -----------------------------------------------------------------------------
// adc_spi_responder
// Emulates the converter side of the LTC2308 serial link. A CONVST rising edge
// samples the selected channel value, a busy counter models the conversion
// time, then the 12-bit result is shifted out on ADC_SDO (MSB first, updated on
// SCK falling edges) while the 6-bit config word is shifted in from ADC_SDI on
// SCK rising edges. A complete config word selects the channel and coding for
// the following conversion.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   ADC_CONVST  in   conversion start from the master (asynchronous)
//   ADC_SCK     in   serial clock from the master (asynchronous)
//   ADC_SDI     in   config bits from the master, MSB first
//   ADC_SDO     out  result bits to the master, MSB first
//   chan_data   in   NCH x 12-bit value bank, one entry per channel
//   cur_chan    out  channel used by the next conversion
//   conv_done   out  one-cycle pulse when a result becomes readable
//   overrun     out  one-cycle pulse on CONVST rising during a conversion
//   diff_req    out  applied config requests differential mode (not emulated)
// -----------------------------------------------------------------------------
module adc_spi_responder
  import adc_pkg::*;
#(
  parameter int CONV_CYCLES = 80,
  parameter int NCH         = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             ADC_CONVST,
  input  logic                             ADC_SCK,
  input  logic                             ADC_SDI,
  output logic                             ADC_SDO,
  input  logic [NCH-1:0][RESULT_W-1:0]     chan_data,
  output logic [2:0]                       cur_chan,
  output logic                             conv_done,
  output logic                             overrun,
  output logic                             diff_req
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic convst_rise;
  logic unused_convst_fall;
  logic sck_rise;
  logic sck_fall;
  logic sdi_meta_reg;
  logic sdi_sync_reg;

  sync_edge u_sync_convst (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ADC_CONVST),
    .rise    (convst_rise),
    .fall    (unused_convst_fall)
  );

  sync_edge u_sync_sck (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ADC_SCK),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  // SDI only needs a level; its two-flop delay matches the SCK path so the bit
  // seen on a detected rising edge is the one the master set up before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdi_meta_reg <= 1'b0;
      sdi_sync_reg <= 1'b0;
    end else begin
      sdi_meta_reg <= ADC_SDI;
      sdi_sync_reg <= sdi_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                state_reg;
  state_t                state_next;
  logic [CNT_W-1:0]      busy_cnt_reg;
  logic [RESULT_W-1:0]   conv_val_reg;
  logic                  conv_uni_reg;
  logic [RESULT_W-1:0]   res_sr_reg;
  logic [3:0]            out_cnt_reg;
  logic [CFG_W-1:0]      cfg_sr_reg;
  logic [2:0]            bit_cnt_reg;
  logic                  apply_pending_reg;
  logic [CFG_W-1:0]      cfg_applied_reg;
  logic                  conv_done_reg;
  logic                  overrun_reg;

  // Strobes from the output process
  logic start_conv;
  logic finish_conv;
  logic overrun_hit;
  logic shift_in;
  logic shift_out;
  logic frame_active;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (convst_rise) state_next = ST_CONV;
      end
      ST_CONV: begin
        // Completion fires on the cycle the counter reaches zero.
        if (busy_cnt_reg <= CNT_W'(1)) state_next = ST_READY;
      end
      ST_READY: begin
        if (convst_rise)              state_next = ST_CONV;
        else if (sck_rise | sck_fall) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (convst_rise) state_next = ST_CONV;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_active = (state_reg == ST_READY) || (state_reg == ST_SHIFT);
    start_conv   = convst_rise && (state_reg != ST_CONV);
    overrun_hit  = convst_rise && (state_reg == ST_CONV);
    finish_conv  = (state_reg == ST_CONV) && (busy_cnt_reg <= CNT_W'(1));
    // A CONVST edge aborts the frame, so it wins over any SCK edge that cycle.
    shift_in     = frame_active && !convst_rise && sck_rise &&
                   (bit_cnt_reg < 3'(CFG_W));
    shift_out    = frame_active && !convst_rise && sck_fall &&
                   (out_cnt_reg < 4'(RESULT_W));
    ADC_SDO      = frame_active && (out_cnt_reg < 4'(RESULT_W)) &&
                   res_sr_reg[RESULT_W-1];
  end

  // ---------------------------------------------------------------------------
  // Datapath: busy counter, conversion capture, result and config shifters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt_reg      <= '0;
      conv_val_reg      <= '0;
      conv_uni_reg      <= 1'b0;
      res_sr_reg        <= '0;
      out_cnt_reg       <= '0;
      cfg_sr_reg        <= '0;
      bit_cnt_reg       <= '0;
      apply_pending_reg <= 1'b0;
      cfg_applied_reg   <= RESET_CFG;
      conv_done_reg     <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      conv_done_reg <= finish_conv;
      overrun_reg   <= overrun_hit;

      if (start_conv) begin
        conv_val_reg <= chan_data[cur_chan];
        conv_uni_reg <= cfg_applied_reg[CFG_UNI];
        busy_cnt_reg <= CNT_W'(CONV_CYCLES);
        bit_cnt_reg  <= '0;
        out_cnt_reg  <= '0;
      end else if (state_reg == ST_CONV && busy_cnt_reg != '0) begin
        busy_cnt_reg <= busy_cnt_reg - 1'b1;
      end

      if (finish_conv) begin
        res_sr_reg  <= to_result(conv_val_reg, conv_uni_reg);
        out_cnt_reg <= '0;
      end else if (shift_out) begin
        res_sr_reg  <= {res_sr_reg[RESULT_W-2:0], 1'b0};
        out_cnt_reg <= out_cnt_reg + 1'b1;
      end

      // A complete word is applied one cycle after its last bit arrives; the
      // channel captured for the result already in flight is unaffected.
      if (apply_pending_reg) begin
        cfg_applied_reg   <= cfg_sr_reg;
        apply_pending_reg <= 1'b0;
      end

      if (shift_in) begin
        cfg_sr_reg  <= {cfg_sr_reg[CFG_W-2:0], sdi_sync_reg};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
        if (bit_cnt_reg == 3'(CFG_W - 1)) apply_pending_reg <= 1'b1;
      end
    end
  end

  // SLP has no emulated effect.
  logic unused_slp;
  assign unused_slp = cfg_applied_reg[CFG_SLP];

  assign cur_chan  = cfg_chan(cfg_applied_reg);
  assign diff_req  = ~cfg_applied_reg[CFG_SD];
  assign conv_done = conv_done_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;

  localparam int CONV_CYCLES = 80;
  localparam int NCH         = 8;
  localparam int LAT_EXP     = CONV_CYCLES + 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  ADC_CONVST;
  logic                  ADC_SCK;
  logic                  ADC_SDI;
  logic                  ADC_SDO;
  logic [NCH-1:0][11:0]  chan_data;
  logic [2:0]            cur_chan;
  logic                  conv_done;
  logic                  overrun;
  logic                  diff_req;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int done_cnt   = 0;
  int ovr_cnt    = 0;

  logic [11:0] sb_q[$];

  adc_spi_responder #(
    .CONV_CYCLES (CONV_CYCLES),
    .NCH         (NCH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ADC_CONVST (ADC_CONVST),
    .ADC_SCK    (ADC_SCK),
    .ADC_SDI    (ADC_SDI),
    .ADC_SDO    (ADC_SDO),
    .chan_data  (chan_data),
    .cur_chan   (cur_chan),
    .conv_done  (conv_done),
    .overrun    (overrun),
    .diff_req   (diff_req)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (conv_done === 1'b1) done_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start a conversion and push the value the frame must return. With
  // 'second' set, a second CONVST arrives 20 clk into the conversion.
  task automatic do_conv(input logic [11:0] exp_val, input bit second);
    int n;
    bit done;
    int ovr_before;
    ovr_before = ovr_cnt;
    sb_q.push_back(exp_val);
    ADC_CONVST = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 4) ADC_CONVST = 1'b0;
      if (second && n == 20) ADC_CONVST = 1'b1;
      if (second && n == 24) ADC_CONVST = 1'b0;
      if (conv_done === 1'b1) done = 1'b1;
    end
    ADC_CONVST = 1'b0;
    $display("conv exp=%03h second=%0d latency=%0d", exp_val, second, n);
    check_val("conv_latency", n, LAT_EXP);
    tick(1);
    check_val("conv_done_width", conv_done, 1'b0);
    check_val("overrun_pulses", ovr_cnt - ovr_before, second ? 1 : 0);
  endtask

  // Clock nbits SCK periods, sending cfg MSB first and collecting SDO before
  // each rising edge. Full frames are compared against the scoreboard.
  task automatic do_frame(input logic [5:0] cfg, input int nbits);
    logic [11:0] rx;
    logic [11:0] exp_val;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      ADC_SDI = (i < 6) ? cfg[5-i] : 1'b0;
      tick(5);
      if (i < 12) rx = {rx[10:0], ADC_SDO};
      ADC_SCK = 1'b1;
      tick(5);
      ADC_SCK = 1'b0;
    end
    ADC_SDI = 1'b0;
    tick(6);
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 1, 0);
    end else begin
      exp_val = sb_q.pop_front();
      $display("frame cfg=%06b bits=%0d rx=%03h exp=%03h cur_chan=%0d", cfg, nbits, rx, exp_val, cur_chan);
      if (nbits >= 12) begin
        check_val("frame_data", rx, exp_val);
        check_val("sdo_after_frame", ADC_SDO, 1'b0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_done;
    reset_n    = 1'b0;
    ADC_CONVST = 1'b0;
    ADC_SCK    = 1'b0;
    ADC_SDI    = 1'b0;
    for (int i = 0; i < NCH; i++) chan_data[i] = 12'(12'h111 * i);
    chan_data[0] = 12'hABC;
    chan_data[1] = 12'h123;
    chan_data[5] = 12'h5A5;
    tick(5);
    reset_n = 1'b1;
    tick(2);
    $display("reset sdo=%0b cur_chan=%0d", ADC_SDO, cur_chan);
    check_val("rst_sdo", ADC_SDO, 1'b0);
    check_val("rst_cur_chan", cur_chan, 3'd0);
    check_val("rst_conv_done", conv_done, 1'b0);
    check_val("rst_overrun", overrun, 1'b0);
    check_val("rst_diff_req", diff_req, 1'b0);

    // Basic conversion and readback on channel 0.
    do_conv(12'hABC, 1'b0);
    do_frame(6'b100010, 12);
    check_val("t1_cur_chan", cur_chan, 3'd0);

    // Channel change applies to the next conversion; extra edges are harmless.
    do_conv(12'hABC, 1'b0);
    do_frame(6'b110010, 14);
    check_val("t2_cur_chan_ch1", cur_chan, 3'd1);
    check_val("t2_diff_req", diff_req, 1'b0);
    do_conv(12'h123, 1'b0);
    do_frame(6'b100010, 12);
    check_val("t2_cur_chan_ch0", cur_chan, 3'd0);

    // Bipolar coding flips the MSB.
    do_conv(12'hABC, 1'b0);
    do_frame(6'b100000, 12);
    chan_data[0] = 12'h800;
    do_conv(12'h000, 1'b0);
    do_frame(6'b100000, 12);
    chan_data[0] = 12'h7FF;
    do_conv(12'hFFF, 1'b0);
    do_frame(6'b100010, 12);

    // Overrun: second CONVST during conversion leaves timing and data alone.
    chan_data[0] = 12'h555;
    do_conv(12'h555, 1'b1);
    do_frame(6'b100010, 12);

    // Aborted frame after 3 config bits: config (channel 5) not applied.
    do_conv(12'h555, 1'b0);
    do_frame(6'b111010, 3);
    check_val("t5_cur_chan_kept", cur_chan, 3'd0);
    do_conv(12'h555, 1'b0);
    do_frame(6'b100010, 12);
    check_val("t5_cur_chan_after", cur_chan, 3'd0);

    // Differential request, then reset during a conversion.
    do_conv(12'h555, 1'b0);
    do_frame(6'b010010, 12);
    check_val("t6_cur_chan_ch1", cur_chan, 3'd1);
    check_val("t6_diff_req", diff_req, 1'b1);
    base_done = done_cnt;
    ADC_CONVST = 1'b1;
    tick(4);
    ADC_CONVST = 1'b0;
    tick(26);
    reset_n = 1'b0;
    tick(2);
    check_val("t6_rst_sdo", ADC_SDO, 1'b0);
    check_val("t6_rst_cur_chan", cur_chan, 3'd0);
    check_val("t6_rst_diff_req", diff_req, 1'b0);
    reset_n = 1'b1;
    tick(120);
    $display("reset_mid_conv done_pulses=%0d cur_chan=%0d", done_cnt - base_done, cur_chan);
    check_val("t6_no_conv_done", done_cnt - base_done, 0);
    check_val("t6_cur_chan_post", cur_chan, 3'd0);
    check_val("t6_sdo_post", ADC_SDO, 1'b0);

    // Recovery after reset.
    do_conv(12'h555, 1'b0);
    do_frame(6'b100010, 12);
    check_val("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable emulator of the LTC2308 side of the ADC serial link: it answers the existing ADC master's CONVST/SCK/SDI traffic and drives ADC_SDO with 12-bit results taken from a per-channel value bank. It stands in for the physical converter on the DE0-Nano header for hardware-in-the-loop runs and joystick-sequence regression, with injected X/Y values replacing the stick. Clocked by the system clock; the master's pins are oversampled.

## Interface
- CONV_CYCLES, 80, clk cycles from CONVST rising edge to result ready (1.6 us at 50 MHz).
- NCH, 8, number of emulated single-ended channels (fixed at 8; channel address is 3 bits).
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ADC_CONVST  in  1  conversion start from the master.
- ADC_SCK  in  1  serial clock from the master.
- ADC_SDI  in  1  config bits from the master, MSB first.
- ADC_SDO  out  1  result bits to the master, MSB first.
- chan_data  in  NCH x 12  value returned for each channel.
- cur_chan  out  3  channel selected for the next conversion.
- conv_done  out  1  one-cycle pulse when a result becomes readable.
- overrun  out  1  one-cycle pulse when CONVST rises while converting.
- diff_req  out  1  level: last applied config has S/D=0 (differential, not emulated).

## Operation
- Input conditioning: each of CONVST, SCK, SDI passes through a 2-flop synchronizer; edges are detected on the synchronized copies.
- Config word (6 bits, MSB first): S/D, O/S, S1, S0, UNI, SLP. Channel = {S1, S0, O/S}. SLP is ignored.
- Reset values: ADC_SDO=0, cur_chan=0, conv_done=0, overrun=0, diff_req=0, applied config 6'b100010 (single-ended, ch0, unipolar), state IDLE.
- States: IDLE, CONV, READY, SHIFT.
- IDLE/READY/SHIFT, CONVST rising: capture chan_data[cur_chan] and the applied UNI bit into the conversion register, load the busy counter with CONV_CYCLES, go to CONV. A frame in progress is aborted; config bits received so far are discarded.
- CONV: counter decrements each cycle; SCK edges are ignored; ADC_SDO held 0. At 0: load the 12-bit shift register with the result (MSB inverted when UNI=0, i.e. two's complement), drive ADC_SDO = bit 11, pulse conv_done, go to READY.
- CONV, CONVST rising: ignored except for the overrun pulse; conversion continues unchanged.
- READY, first SCK edge: go to SHIFT.
- SHIFT, SCK rising: shift the synchronized SDI into the config register and increment the bit counter (saturating at 6). On the 6th bit, apply the word: cur_chan, diff_req and UNI update the next cycle. The new channel applies to the next CONVST, not to the result being shifted.
- SHIFT, SCK falling: shift the result left and drive the next bit. After 12 falling edges ADC_SDO = 0 until the next conv_done.
- More than 6 rising or 12 falling edges in one frame: the extras change nothing.
- Reset asserted mid-frame or mid-conversion: immediate return to reset values; no partial config is kept.

## Timing
- ADC_SCK high and low phases must each be ≥ 4 clk cycles. ADC_CONVST high must be ≥ 3 clk cycles.
- Pin-to-detect latency is 3 clk (2 synchronizer stages plus the edge register). ADC_SDO changes 1 clk after a detected SCK falling edge, so it is valid ≤ 4 clk after the pin edge.
- conv_done asserts CONV_CYCLES + 3 clk after the CONVST pin rises. The master must not clock SCK before that.
- cur_chan updates 1 clk after the 6th detected SCK rising edge.

## Structure
- Shared package adc_pkg: state enum, config bit-position constants (CFG_SD=5 … CFG_SLP=0), RESET_CFG=6'b100010, RESULT_W=12, CFG_W=6.
- One sub-module: sync_edge (2-flop synchronizer plus rise/fall pulse outputs), instantiated for CONVST and SCK; SDI uses the synchronizer only.
- Top holds the FSM, the busy counter, and the config and result shift registers.

## Test plan
- After reset, chan_data[0]=12'hABC, CONVST pulse, then a 12-bit frame with SDI=6'b100010 → conv_done at CONV_CYCLES+3; SDO reads 0xABC; cur_chan stays 0.
- Frame 1 writes SDI=6'b110010 (ch1), chan_data[1]=12'h123; frame 2 (CONVST, shift) → frame 1 still returns the ch0 value, frame 2 returns 0x123; cur_chan=1 after frame 1's 6th rising edge.
- Config 6'b100000 (UNI=0), chan_data[0]=12'h800 → next frame reads 0x000; value 12'h7FF reads 0xFFF.
- Second CONVST 20 clk after the first → overrun pulses once; conv_done still at the original time; result unchanged.
- CONVST after only 3 SCK rising edges of a frame → config not applied (cur_chan unchanged); the new conversion proceeds normally.
- reset_n low during CONV → SDO=0, no conv_done; cur_chan=0 after release.
